// File: rtl/wm_pkg.sv
// Controller state codes shared between the washing-machine controller FSM and its phase timer.
// No logic lives here; consumers cast the codes to their own state width.
package wm_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_code_t;

  localparam state_code_t STATE_IDLE       = 3'd0;
  localparam state_code_t STATE_FILL_WATER = 3'd2;
  localparam state_code_t STATE_HEAT_WATER = 3'd3;
  localparam state_code_t STATE_WASH       = 3'd4;
  localparam state_code_t STATE_RINSE      = 3'd5;
  localparam state_code_t STATE_SPIN       = 3'd6;

endpackage

// File: rtl/wm_phase_counter.sv
// Saturating up-counter: clears on load_zero, advances on enable until it equals target, then holds.
// Count is registered; at_target is a combinational compare of the registered count.
module wm_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_zero,
  input  logic             enable,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] count,
  output logic             at_target
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_zero) begin
      count_d = '0;
    end else if (enable && (count_q < target)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign at_target = (count_q == target);

endmodule

// File: rtl/wm_phase_timer.sv
// Times each controller phase with one reloadable counter; completion flags and done_pulse appear
// TARGET edges after phase entry, pause freezes the count, and re-entering a phase restarts it.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int STATE_W    = wm_pkg::STATE_W,
  parameter int CNT_W      = 8,
  parameter int FILL_TIME  = 2,
  parameter int HEAT_TIME  = 3,
  parameter int WASH_TIME  = 5,
  parameter int RINSE_TIME = 3,
  parameter int SPIN_TIME  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  input  logic               pause,
  output logic               sig_Full,
  output logic               sig_Temperature,
  output logic               sig_Completed,
  output logic               done_pulse,
  output logic [CNT_W-1:0]   remaining,
  output logic               active
);

  localparam int MAX_T = (1 << CNT_W) - 1;

  if (FILL_TIME > MAX_T || HEAT_TIME > MAX_T || WASH_TIME > MAX_T ||
      RINSE_TIME > MAX_T || SPIN_TIME > MAX_T) begin : g_time_chk
    $error("wm_phase_timer: a phase time does not fit in CNT_W=%0d bits", CNT_W);
  end

  localparam logic [STATE_W-1:0] S_IDLE  = STATE_W'(STATE_IDLE);
  localparam logic [STATE_W-1:0] S_FILL  = STATE_W'(STATE_FILL_WATER);
  localparam logic [STATE_W-1:0] S_HEAT  = STATE_W'(STATE_HEAT_WATER);
  localparam logic [STATE_W-1:0] S_WASH  = STATE_W'(STATE_WASH);
  localparam logic [STATE_W-1:0] S_RINSE = STATE_W'(STATE_RINSE);
  localparam logic [STATE_W-1:0] S_SPIN  = STATE_W'(STATE_SPIN);

  function automatic logic [CNT_W-1:0] phase_target(input logic [STATE_W-1:0] s);
    case (s)
      S_FILL:  phase_target = CNT_W'(FILL_TIME);
      S_HEAT:  phase_target = CNT_W'(HEAT_TIME);
      S_WASH:  phase_target = CNT_W'(WASH_TIME);
      S_RINSE: phase_target = CNT_W'(RINSE_TIME);
      S_SPIN:  phase_target = CNT_W'(SPIN_TIME);
      default: phase_target = '0;
    endcase
  endfunction

  function automatic logic is_timed(input logic [STATE_W-1:0] s);
    is_timed = (s == S_FILL) || (s == S_HEAT) || (s == S_WASH) ||
               (s == S_RINSE) || (s == S_SPIN);
  endfunction

  logic [STATE_W-1:0] prev_state_q;
  logic               done_q, done_d;
  logic               done_pulse_q, done_pulse_d;
  logic               active_q, active_d;
  logic [CNT_W-1:0]   tgt_cur, count;
  logic               entry, cnt_en, at_target, rises;

  assign entry   = (state != prev_state_q);
  assign tgt_cur = phase_target(prev_state_q);
  assign cnt_en  = !entry && is_timed(prev_state_q) && !pause;
  assign rises   = cnt_en && !at_target && ((count + CNT_W'(1)) == tgt_cur);

  wm_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock     (clock),
    .reset     (reset),
    .load_zero (entry),
    .enable    (cnt_en),
    .target    (tgt_cur),
    .count     (count),
    .at_target (at_target)
  );

  always_comb begin
    done_d       = done_q;
    done_pulse_d = 1'b0;
    if (entry) begin
      // A zero-length timed phase completes on its own entry edge.
      done_d       = is_timed(state) && (phase_target(state) == '0);
      done_pulse_d = done_d && !done_pulse_q;
    end else if (rises) begin
      done_d       = 1'b1;
      done_pulse_d = 1'b1;
    end
    active_d = is_timed(state) && !pause && !done_d;
  end

  // prev_state always follows state: on entry it takes the new code, otherwise they are equal.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_state_q <= S_IDLE;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      prev_state_q <= state;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      active_q     <= active_d;
    end
  end

  assign sig_Full        = done_q && (prev_state_q == S_FILL);
  assign sig_Temperature = done_q && (prev_state_q == S_HEAT);
  assign sig_Completed   = done_q && ((prev_state_q == S_WASH) ||
                                      (prev_state_q == S_RINSE) ||
                                      (prev_state_q == S_SPIN));
  assign done_pulse      = done_pulse_q;
  assign remaining       = tgt_cur - count;
  assign active          = active_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Phase timer bench: directed phase sequences plus random state/pause/reset traffic, checked every
// cycle against an elapsed-time model, with literal expectations at the key edges.
module tb_wm_phase_timer;
  import wm_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       pause;
  logic [2:0] state;

  logic       sig_Full, sig_Temperature, sig_Completed, done_pulse, active;
  logic [7:0] remaining;
  logic       z_full, z_temp, z_comp, z_pulse, z_active;
  logic [3:0] z_rem;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  wm_phase_timer dut (
    .clock(clock), .reset(reset), .state(state), .pause(pause),
    .sig_Full(sig_Full), .sig_Temperature(sig_Temperature), .sig_Completed(sig_Completed),
    .done_pulse(done_pulse), .remaining(remaining), .active(active)
  );

  wm_phase_timer #(.CNT_W(4), .FILL_TIME(0)) dut_zero (
    .clock(clock), .reset(reset), .state(state), .pause(pause),
    .sig_Full(z_full), .sig_Temperature(z_temp), .sig_Completed(z_comp),
    .done_pulse(z_pulse), .remaining(z_rem), .active(z_active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference: a phase is "elapsed cycles since entry" capped at its duration.
  function automatic int tgt_of(input logic [2:0] s);
    case (s)
      STATE_FILL_WATER: return 2;
      STATE_HEAT_WATER: return 3;
      STATE_WASH:       return 5;
      STATE_RINSE:      return 3;
      STATE_SPIN:       return 3;
      default:          return 0;
    endcase
  endfunction

  function automatic bit timed_of(input logic [2:0] s);
    return s inside {STATE_FILL_WATER, STATE_HEAT_WATER, STATE_WASH, STATE_RINSE, STATE_SPIN};
  endfunction

  logic [2:0] m_phase = STATE_IDLE;
  int         m_el = 0;
  bit         m_done = 0, m_pulse = 0, m_active = 0, m_was = 0, model_on = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_phase = STATE_IDLE; m_el = 0; m_done = 0; m_pulse = 0; m_active = 0;
      model_on = 1;
    end else begin
      m_was = m_done;
      if (state != m_phase) begin
        m_phase = state;
        m_el = 0;
      end else if (timed_of(m_phase) && !pause && m_el < tgt_of(m_phase)) begin
        m_el++;
      end
      m_done   = timed_of(m_phase) && (m_el >= tgt_of(m_phase));
      m_pulse  = m_done && !m_was;
      m_active = timed_of(m_phase) && !pause && !m_done;
    end
    #1;
    if (model_on) begin
      chk("model sig_Full", sig_Full, m_done && m_phase == STATE_FILL_WATER);
      chk("model sig_Temperature", sig_Temperature, m_done && m_phase == STATE_HEAT_WATER);
      chk("model sig_Completed", sig_Completed,
          m_done && (m_phase inside {STATE_WASH, STATE_RINSE, STATE_SPIN}));
      chk("model done_pulse", done_pulse, m_pulse);
      chk("model remaining", remaining, timed_of(m_phase) ? tgt_of(m_phase) - m_el : 0);
      chk("model active", active, m_active);
    end
  end

  initial begin
    reset = 1'b1; state = STATE_IDLE; pause = 1'b0;
    tick();
    // Test 1: idle after reset, then reset mid-WASH
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle remaining", remaining, 0);
      chk("idle flags", {sig_Full, sig_Temperature, sig_Completed, done_pulse, active}, 0);
    end
    chk("idle zero-dut full", z_full, 0);
    state = STATE_WASH;
    repeat (4) tick();
    chk("wash count3 remaining", remaining, 2);
    reset = 1'b1;
    tick();
    chk("reset remaining", remaining, 0);
    chk("reset active", active, 0);
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rewash not done", sig_Completed, 0);
    end
    tick();
    chk("rewash done", sig_Completed, 1);
    chk("rewash pulse", done_pulse, 1);

    // Test 2: FILL latency, saturation, and zero-length FILL on the second instance
    state = STATE_IDLE;
    tick();
    state = STATE_FILL_WATER;
    tick();
    chk("fill E0 full", sig_Full, 0);
    chk("fill E0 remaining", remaining, 2);
    chk("fill E0 active", active, 1);
    chk("zero fill full", z_full, 1);
    chk("zero fill pulse", z_pulse, 1);
    tick();
    chk("fill E1 full", sig_Full, 0);
    chk("zero fill pulse drop", z_pulse, 0);
    tick();
    chk("fill E2 full", sig_Full, 1);
    chk("fill E2 pulse", done_pulse, 1);
    chk("fill E2 remaining", remaining, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("fill hold full", sig_Full, 1);
      chk("fill hold pulse", done_pulse, 0);
    end

    // Test 3: pause mid-WASH
    state = STATE_WASH;
    repeat (3) tick();
    chk("wash count2 remaining", remaining, 3);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("paused remaining", remaining, 3);
      chk("paused active", active, 0);
    end
    pause = 1'b0;
    repeat (2) tick();
    chk("wash resume not done", sig_Completed, 0);
    tick();
    chk("wash resume done", sig_Completed, 1);

    // Test 4: WASH -> RINSE drops sig_Completed for a cycle
    state = STATE_RINSE;
    tick();
    chk("rinse entry completed", sig_Completed, 0);
    chk("rinse entry remaining", remaining, 3);
    repeat (2) tick();
    chk("rinse E2 completed", sig_Completed, 0);
    tick();
    chk("rinse done", sig_Completed, 1);
    chk("rinse pulse", done_pulse, 1);

    // Test 5: entry into HEAT while paused
    state = STATE_FILL_WATER;
    repeat (3) tick();
    pause = 1'b1; state = STATE_HEAT_WATER;
    tick();
    chk("heat paused entry remaining", remaining, 3);
    chk("heat paused entry full", sig_Full, 0);
    repeat (2) tick();
    chk("heat paused hold", remaining, 3);
    pause = 1'b0;
    repeat (2) tick();
    chk("heat not yet", sig_Temperature, 0);
    tick();
    chk("heat done", sig_Temperature, 1);

    // Random traffic, checked by the model process
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 25) state = 3'($urandom_range(0, 7));
      pause = ($urandom_range(0, 99) < 20);
      reset = ($urandom_range(0, 199) < 3);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wm_phase_timer.md
Name: wm_phase_timer

Overview:
Parametrised successor to the washing-machine phase Timer. It times each controller phase (fill, heat, wash, rinse, spin) with a single reloadable counter, not one fixed-width counter per phase. Phase durations and counter width are parameters. It adds a pause input (door open / user hold), per-phase restart on phase entry, a one-cycle done pulse and a remaining-time output. It sits beside the controller FSM, takes its state code and returns the completion flags.

Parameters:
STATE_W, 3, width of controller state code
CNT_W, 8, counter / remaining-time width
FILL_TIME, 2, cycles in FILL_WATER until sig_Full
HEAT_TIME, 3, cycles in HEAT_WATER until sig_Temperature
WASH_TIME, 5, cycles in WASH until sig_Completed
RINSE_TIME, 3, cycles in RINSE until sig_Completed
SPIN_TIME, 3, cycles in SPIN until sig_Completed

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
state  in  STATE_W  current controller state code
pause  in  1  1 = freeze timing in current phase
sig_Full  out  1  fill time reached (level)
sig_Temperature  out  1  heat time reached (level)
sig_Completed  out  1  wash/rinse/spin time reached (level)
done_pulse  out  1  one-cycle pulse when any phase reaches its time
remaining  out  CNT_W  target minus count in timed phase, else 0
active  out  1  timed phase, not paused, not yet done

Behaviour:
- Reset (sync, active-high, highest priority): count=0, done=0, prev_state=STATE_IDLE, every output 0.
- Target is selected from the phase by a combinational LUT. Non-timed states have target 0 and are not timed.
- Phase entry: a clock edge where state != prev_state. On that edge: prev_state<=state, count<=0, done<=0, done_pulse<=0. If the new state is timed with target 0, done<=1 and done_pulse<=1 on the same edge.
- Counting: on an edge with state==prev_state, timed phase, pause=0 and count<target: count<=count+1. If count+1==target, done<=1 and done_pulse<=1.
- Latency: done first reads 1 exactly TARGET edges after the entry edge, with no pause.
- Saturation: once count==target, count holds and done stays 1 until phase exit. There is no wrap-around.
- Pause: freezes count. done holds its value. done_pulse is 0. active is 0. Phase entry overrides pause, so the count is cleared even if pause=1.
- done_pulse is 1 only on the cycle after the edge where done rose. It is never asserted two cycles in a row.
- Outputs are registered, one cycle after the done edge:
  - sig_Full = done and prev_state==FILL
  - sig_Temperature = done and prev_state==HEAT
  - sig_Completed = done and prev_state in {WASH, RINSE, SPIN}
- All flags drop on the edge after the phase is left. Back-to-back WASH->RINSE gives sig_Completed=0 for at least one cycle (the entry edge clears done).
- Non-timed state (IDLE, etc.): count=0, done=0, remaining=0, active=0.
- Unknown state codes are treated as non-timed.
- remaining = target - count, registered with count.
- Elaboration check: every *_TIME must be <= 2**CNT_W-1, else $error.

Decomposition:
- Package wm_pkg holds the state-code constants shared with the controller: STATE_IDLE=0, STATE_FILL_WATER=2, STATE_HEAT_WATER=3, STATE_WASH=4, STATE_RINSE=5, STATE_SPIN=6, plus STATE_W.
- One sub-module, wm_phase_counter: a CNT_W saturating counter with ports load_zero, enable, target, count, at_target.
- The phase-to-target LUT and the flag decode stay in the top.

Test Plan:
1. Reset, then IDLE for 5 cycles -> all outputs 0, remaining=0; reset asserted mid-WASH (count=3) -> next edge all 0, and re-entering WASH times a full 5 cycles.
2. state=FILL at edge E0, pause=0 -> sig_Full=0 through E1, count=2 and done at E2, sig_Full=1 and done_pulse=1 for one cycle after E2. Holding FILL 10 more cycles -> sig_Full stays 1, remaining=0, no further pulse.
3. WASH with pause=1 for 4 cycles after count=2 -> count holds 2, remaining=3, active=0. Release -> sig_Completed rises 3 edges later, 9 edges after entry in total.
4. WASH done then state->RINSE -> sig_Completed falls for 1 cycle and rises 3 edges after RINSE entry. done_pulse fires once per phase.
5. Phase entry with pause=1 (HEAT from FILL, pause held) -> count cleared to 0 and remaining=3; nothing counts until pause=0.
6. Override FILL_TIME=0, CNT_W=4 -> sig_Full=1 one cycle after the entry edge. WASH_TIME=20 with CNT_W=4 -> elaboration error.
